instr_encoder: RTL and testbench
================================

# instr_encoder

Pipelined RV32I instruction encoder: accepts decoded fields (format, opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake. It range-checks the immediate and packs a 32-bit instruction word into a small output FIFO. It is the inverse of the decode-stage immediate extraction and uses the same 3-bit format code. It sits in the debug/instruction-injection path and feeds generated instructions into fetch and test harnesses.

## Interface
- DEPTH, 2: output FIFO entries (power of two, ≥2)
- CNT_W, 16: width of the statistics counters
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- fmt  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110/111 illegal
- opcode  in  7  instr[6:0]
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25], R-type only
- imm  in  32  byte offset / value, two's complement
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head this cycle
- out_instr  out  32  encoded word (0 when out_err)
- out_err  out  1  immediate unrepresentable or fmt illegal
- enc_count  out  CNT_W  words written to FIFO, saturating
- err_count  out  CNT_W  error words written, saturating

## Operation
- Stage S1: on in_valid && in_ready, register all fields and s1_valid=1. Compute err from the registered fields.
- Range rules (err=1 if violated):
  - I, S: imm sign-extended from bit 11 equals imm.
  - B: sign-extended from bit 12 equals imm, and imm[0]=0.
  - J: sign-extended from bit 20 equals imm, and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
  - fmt 110/111: err.
- Packing (combinational from S1):
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - U: {imm[31:12],rd,opcode}
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - err: word forced to 32'h0.
- FIFO write: when s1_valid && (fifo not full || pop this cycle), write {word, err}, clear or reload S1. enc_count+1; err_count+1 if err. Both saturate at all-ones.
- FIFO pop: out_valid && out_ready. out_instr and out_err show the head combinationally from storage. Pointers wrap modulo DEPTH.
- in_ready = !s1_valid || fifo not full || (out_valid && out_ready). Full throughput of one word/cycle with out_ready held high.
- Simultaneous push and pop when full: both occur, count unchanged.
- Output data stays stable while out_valid && !out_ready.

## Timing
- Reset (async, any cycle, including mid-stream): s1_valid=0, FIFO empty, pointers=0, counters=0. Outputs: out_valid=0, out_instr=0, out_err=0, in_ready=1. In-flight words are discarded.
- Latency: accept at edge N → FIFO write at edge N+1 → out_valid=1 after edge N+1, given space.
- Backpressure: with out_ready=0, exactly DEPTH+1 words are accepted. in_ready falls in the cycle after the last accept.
- No combinational path from in_valid to out_valid. out_ready → in_ready is combinational.

## Test plan
- I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 → out_instr 0x00500093, out_err 0, out_valid two edges after accept.
- S, opcode 0100011, funct3=010, rs1=1, rs2=2, imm=8 → 0x0020A423. J, opcode 1101111, rd=1, imm=-4 → 0xFFDFF0EF. U, opcode 0110111, rd=5, imm=0x12345000 → 0x123452B7.
- Errors: B imm=3 → out_err 1, out_instr 0. I imm=2048 → err. fmt=111 → err. After these 3 words, err_count=3.
- Backpressure: out_ready=0, in_valid=1 constant → 3 accepts (DEPTH=2), then in_ready=0. Release out_ready → words drain in order and in_ready reasserts the same cycle as the first pop.
- Streaming: 100 random legal words with out_ready=1 → one output per cycle. Each word decoded back via the decode immediate extraction equals the original imm. enc_count=100.
- Assert reset while the FIFO holds 2 words and S1 is valid → out_valid=0 and counters=0 immediately. The next accepted word is output with the correct value.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: registers decoded fields, range-checks the immediate,
// packs a 32-bit word and queues {word, err} in a small output FIFO.
module instr_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_J = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } entry_t;

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s1_err;
    logic [31:0] s1_word;

    entry_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic pop;
    logic push;
    logic accept;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != CW'(0));
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!full || pop);
    assign in_ready  = !s1_valid || !full || pop;
    assign accept    = in_valid && in_ready;

    assign out_instr = mem[rd_ptr].word;
    assign out_err   = mem[rd_ptr].err;

    // Immediate must survive the truncation the target format applies.
    always_comb begin
        s1_err = 1'b0;
        case (s1_fmt)
            FMT_I, FMT_S: s1_err = ({{20{s1_imm[11]}}, s1_imm[11:0]} != s1_imm);
            FMT_B:        s1_err = ({{19{s1_imm[12]}}, s1_imm[12:0]} != s1_imm) || s1_imm[0];
            FMT_J:        s1_err = ({{11{s1_imm[20]}}, s1_imm[20:0]} != s1_imm) || s1_imm[0];
            FMT_U:        s1_err = (s1_imm[11:0] != 12'd0);
            FMT_R:        s1_err = 1'b0;
            default:      s1_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_word = 32'h0;
        case (s1_fmt)
            FMT_I: s1_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B: s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                              s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_J: s1_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                              s1_rd, s1_opcode};
            FMT_U: s1_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_R: s1_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            default: s1_word = 32'h0;
        endcase
        if (s1_err) begin
            s1_word = 32'h0;
        end
    end

    // Stage 1 field register; a push frees it in the same cycle a new accept reloads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= 3'd0;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_funct7 <= 7'd0;
            s1_imm    <= 32'h0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_fmt    <= fmt;
            s1_opcode <= opcode;
            s1_rd     <= rd;
            s1_rs1    <= rs1;
            s1_rs2    <= rs2;
            s1_funct3 <= funct3;
            s1_funct7 <= funct7;
            s1_imm    <= imm;
        end else if (push) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{word: s1_word, err: s1_err};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Saturating statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (push) begin
            if (enc_count != '1) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (s1_err && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected {word, err} per accepted input.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       fmt;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } stim_t;

    typedef struct {
        logic [32:0] want;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } sb_t;

    sb_t sbq[$];
    int  checks;
    int  failures;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                                 input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im);
        stim_t s;
        s.fmt = f; s.opc = o; s.rd = d; s.rs1 = a; s.rs2 = b; s.f3 = f3; s.f7 = f7; s.imm = im;
        return s;
    endfunction

    // Reference encoder: field-by-field placement and signed range limits.
    function automatic logic [32:0] model(input stim_t s);
        logic [31:0] w;
        logic        e;
        int          v;
        w = 32'h0;
        e = 1'b0;
        v = $signed(s.imm);
        w[6:0] = s.opc;
        case (s.fmt)
            3'd0: begin
                e = (v < -2048) || (v > 2047);
                w[11:7] = s.rd; w[14:12] = s.f3; w[19:15] = s.rs1; w[31:20] = s.imm[11:0];
            end
            3'd1: begin
                e = (v < -2048) || (v > 2047);
                w[11:7] = s.imm[4:0]; w[14:12] = s.f3; w[19:15] = s.rs1;
                w[24:20] = s.rs2; w[31:25] = s.imm[11:5];
            end
            3'd2: begin
                e = (v < -4096) || (v > 4095) || s.imm[0];
                w[7] = s.imm[11]; w[11:8] = s.imm[4:1]; w[14:12] = s.f3; w[19:15] = s.rs1;
                w[24:20] = s.rs2; w[30:25] = s.imm[10:5]; w[31] = s.imm[12];
            end
            3'd3: begin
                e = (v < -1048576) || (v > 1048575) || s.imm[0];
                w[11:7] = s.rd; w[19:12] = s.imm[19:12]; w[20] = s.imm[11];
                w[30:21] = s.imm[10:1]; w[31] = s.imm[20];
            end
            3'd4: begin
                e = (s.imm[11:0] != 12'h0);
                w[11:7] = s.rd; w[31:12] = s.imm[31:12];
            end
            3'd5: begin
                w[11:7] = s.rd; w[14:12] = s.f3; w[19:15] = s.rs1;
                w[24:20] = s.rs2; w[31:25] = s.f7;
            end
            default: e = 1'b1;
        endcase
        if (e) w = 32'h0;
        return {w, e};
    endfunction

    // Decode-stage immediate extraction.
    function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd0: return {{20{w[31]}}, w[31:20]};
            3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            3'd4: return {w[31:12], 12'h0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic stim_t rand_legal();
        stim_t s;
        logic [31:0] r;
        r = $urandom;
        s = mk(3'($urandom_range(0, 5)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), 32'h0);
        case (s.fmt)
            3'd0, 3'd1: s.imm = {{20{r[11]}}, r[11:0]};
            3'd2:       s.imm = {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       s.imm = {{11{r[20]}}, r[20:1], 1'b0};
            3'd4:       s.imm = {r[31:12], 12'h0};
            default:    s.imm = r;
        endcase
        return s;
    endfunction

    task automatic drive(input stim_t s);
        in_valid = 1'b1;
        fmt = s.fmt; opcode = s.opc; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
        funct3 = s.f3; funct7 = s.f7; imm = s.imm;
    endtask

    function automatic sb_t mk_sb(input logic [32:0] want, input stim_t s);
        sb_t e;
        e.want = want; e.fmt = s.fmt; e.imm = s.imm;
        return e;
    endfunction

    // One clock: sample handshakes at the falling edge, return just after the rising edge.
    task automatic tick(output bit acc, output bit pop, output logic [32:0] obs, output logic rdy);
        @(negedge clk);
        rdy = in_ready;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        obs = {out_instr, out_err};
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
        if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b want=0", out_err); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (enc_count !== '0) begin failures++; $display("FAIL reset_enc_count got=%0d want=0", enc_count); end
        if (err_count !== '0) begin failures++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        out_ready = 1'b0;
        drive(mk(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_accept got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b want=0", out_valid); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b want=1", out_valid); end
        if ({out_instr, out_err} !== {32'h00500093, 1'b0}) begin
            failures++; $display("FAIL lat_word got=%h/%b want=00500093/0", out_instr, out_err);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_popped got=%b want=0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        stim_t st[3];
        logic [32:0] want[3];
        bit acc, pop;
        logic [32:0] obs;
        logic rdy;
        sb_t e;
        int idx, cyc;
        st[0] = mk(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        st[1] = mk(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        st[2] = mk(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        want[0] = {32'h0020A423, 1'b0};
        want[1] = {32'hFFDFF0EF, 1'b0};
        want[2] = {32'h123452B7, 1'b0};
        out_ready = 1'b1;
        idx = 0; cyc = 0;
        while ((idx < 3 || sbq.size() != 0) && cyc < 50) begin
            if (idx < 3) drive(st[idx]); else in_valid = 1'b0;
            tick(acc, pop, obs, rdy);
            if (pop) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e.want) begin failures++; $display("FAIL vec_word got=%h want=%h", obs, e.want); end
            end
            if (acc) begin sbq.push_back(mk_sb(want[idx], st[idx])); idx++; end
            cyc++;
        end
        in_valid = 1'b0;
        checks += 2;
        if (cyc >= 50) begin failures++; $display("FAIL vec_timeout got=%0d cycles want<50", cyc); end
        if (enc_count !== CNT_W'(4)) begin failures++; $display("FAIL vec_enc_count got=%0d want=4", enc_count); end
    endtask

    task automatic test_errors();
        stim_t st[3];
        bit acc, pop;
        logic [32:0] obs;
        logic rdy;
        sb_t e;
        int idx, cyc;
        st[0] = mk(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        st[1] = mk(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        st[2] = mk(3'd7, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        out_ready = 1'b1;
        idx = 0; cyc = 0;
        while ((idx < 3 || sbq.size() != 0) && cyc < 50) begin
            if (idx < 3) drive(st[idx]); else in_valid = 1'b0;
            tick(acc, pop, obs, rdy);
            if (pop) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e.want) begin failures++; $display("FAIL err_word got=%h want=%h", obs, e.want); end
            end
            if (acc) begin sbq.push_back(mk_sb({32'h0, 1'b1}, st[idx])); idx++; end
            cyc++;
        end
        in_valid = 1'b0;
        checks += 3;
        if (cyc >= 50) begin failures++; $display("FAIL err_timeout got=%0d cycles want<50", cyc); end
        if (err_count !== CNT_W'(3)) begin failures++; $display("FAIL err_count got=%0d want=3", err_count); end
        if (enc_count !== CNT_W'(7)) begin failures++; $display("FAIL err_enc_count got=%0d want=7", enc_count); end
    endtask

    task automatic test_backpressure();
        stim_t st[4];
        bit acc, pop;
        logic [32:0] obs;
        logic rdy;
        sb_t e;
        int idx, cyc, accepts;
        bit first;
        for (int i = 0; i < 4; i++) st[i] = rand_legal();
        out_ready = 1'b0;
        idx = 0; accepts = 0; rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (idx < 4) drive(st[idx]); else in_valid = 1'b0;
            tick(acc, pop, obs, rdy);
            if (acc) begin sbq.push_back(mk_sb(model(st[idx]), st[idx])); idx++; accepts++; end
        end
        checks += 2;
        if (accepts != int'(DEPTH) + 1) begin failures++; $display("FAIL bp_accepts got=%0d want=%0d", accepts, DEPTH + 1); end
        if (rdy !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b want=0", rdy); end
        out_ready = 1'b1;
        first = 1'b1; cyc = 0;
        while ((idx < 4 || sbq.size() != 0) && cyc < 50) begin
            if (idx < 4) drive(st[idx]); else in_valid = 1'b0;
            tick(acc, pop, obs, rdy);
            if (first) begin
                checks++;
                if (rdy !== 1'b1) begin failures++; $display("FAIL bp_in_ready_pop got=%b want=1", rdy); end
                first = 1'b0;
            end
            if (pop) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e.want) begin failures++; $display("FAIL bp_order got=%h want=%h", obs, e.want); end
            end
            if (acc) begin sbq.push_back(mk_sb(model(st[idx]), st[idx])); idx++; end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc >= 50) begin failures++; $display("FAIL bp_timeout got=%0d cycles want<50", cyc); end
    endtask

    task automatic test_stream();
        stim_t cur;
        bit acc, pop;
        logic [32:0] obs;
        logic rdy;
        sb_t e;
        int idx, cyc;
        apply_reset();
        out_ready = 1'b1;
        cur = rand_legal();
        idx = 0; cyc = 0;
        while ((idx < 100 || sbq.size() != 0) && cyc < 400) begin
            if (idx < 100) drive(cur); else in_valid = 1'b0;
            tick(acc, pop, obs, rdy);
            if (pop) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e.want) begin failures++; $display("FAIL stream_word got=%h want=%h", obs, e.want); end
                if (e.fmt != 3'd5) begin
                    checks++;
                    if (decode_imm(e.fmt, obs[32:1]) !== e.imm) begin
                        failures++;
                        $display("FAIL stream_decode got=%h want=%h", decode_imm(e.fmt, obs[32:1]), e.imm);
                    end
                end
            end
            if (acc) begin
                sbq.push_back(mk_sb(model(cur), cur));
                idx++;
                cur = rand_legal();
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks += 3;
        if (cyc != 102) begin failures++; $display("FAIL stream_cycles got=%0d want=102", cyc); end
        if (enc_count !== CNT_W'(100)) begin failures++; $display("FAIL stream_enc_count got=%0d want=100", enc_count); end
        if (err_count !== CNT_W'(0)) begin failures++; $display("FAIL stream_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_midstream_reset();
        stim_t st;
        bit acc, pop;
        logic [32:0] obs;
        logic rdy;
        sb_t e;
        int idx, cyc;
        apply_reset();
        out_ready = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 3 && cyc < 20) begin
            drive(rand_legal());
            tick(acc, pop, obs, rdy);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks += 2;
        if (idx != 3) begin failures++; $display("FAIL mr_fill got=%0d want=3", idx); end
        if (enc_count !== CNT_W'(2)) begin failures++; $display("FAIL mr_pre_count got=%0d want=2", enc_count); end
        reset = 1'b1;
        #2;
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_out_valid got=%b want=0", out_valid); end
        if (out_instr !== 32'h0) begin failures++; $display("FAIL mr_out_instr got=%h want=0", out_instr); end
        if (out_err !== 1'b0) begin failures++; $display("FAIL mr_out_err got=%b want=0", out_err); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_in_ready got=%b want=1", in_ready); end
        if (enc_count !== '0) begin failures++; $display("FAIL mr_enc_count got=%0d want=0", enc_count); end
        if (err_count !== '0) begin failures++; $display("FAIL mr_err_count got=%0d want=0", err_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        st = mk(3'd5, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'b0100000, 32'h0);
        out_ready = 1'b1;
        idx = 0; cyc = 0;
        while ((idx < 1 || sbq.size() != 0) && cyc < 20) begin
            if (idx < 1) drive(st); else in_valid = 1'b0;
            tick(acc, pop, obs, rdy);
            if (pop) begin
                e = sbq.pop_front();
                checks++;
                if (obs !== e.want) begin failures++; $display("FAIL mr_after got=%h want=%h", obs, e.want); end
            end
            if (acc) begin sbq.push_back(mk_sb({32'h405201B3, 1'b0}, st)); idx++; end
            cyc++;
        end
        in_valid = 1'b0;
        checks += 2;
        if (cyc >= 20) begin failures++; $display("FAIL mr_timeout got=%0d cycles want<20", cyc); end
        if (enc_count !== CNT_W'(1)) begin failures++; $display("FAIL mr_post_count got=%0d want=1", enc_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'h0;
        test_reset();
        test_latency();
        test_vectors();
        test_errors();
        test_backpressure();
        test_stream();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
